instr_fetch_unit: RTL

Program-counter and instruction-fetch stage driven directly by `ControlUnit` stage enables. Each `IF` pulse fetches one word from a synchronous instruction memory. The fetched word is latched into the instruction register, and the PC is advanced or redirected. Downstream, the `ID`/`REG` stages consume `instr`. `JU`/`BR` pulses from the control unit redirect the PC using targets supplied by the decode/execute logic.

---
 rtl/cpu_pkg.sv | 19 +
 rtl/pc_next_calc.sv | 30 +++
 rtl/instr_fetch_unit.sv | 132 +++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM states, redirect kinds and instruction field widths.
package cpu_pkg;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam int unsigned JTARGET_W        = 26;
    localparam int unsigned BOFF_W           = 16;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } ifu_state_t;

    typedef enum logic [1:0] {
        RD_NONE   = 2'd0,
        RD_JUMP   = 2'd1,
        RD_BRANCH = 2'd2
    } redir_kind_t;

endpackage

// File: rtl/pc_next_calc.sv
// Combinational next-PC mux: sequential (+4), jump (region-relative) or branch (PC-relative).
module pc_next_calc
    import cpu_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic [ADDR_W-1:0]    pc,
    input  redir_kind_t          kind,
    input  logic [BOFF_W-1:0]    br_offset,
    input  logic [JTARGET_W-1:0] ju_target,
    output logic [ADDR_W-1:0]    pc_plus4,
    output logic [ADDR_W-1:0]    pc_next
);

    logic [ADDR_W-1:0] br_disp;

    assign pc_plus4 = pc + ADDR_W'(4);
    // Word offset sign-extended and scaled to bytes; sum wraps modulo 2^ADDR_W.
    assign br_disp  = {{(ADDR_W-BOFF_W-2){br_offset[BOFF_W-1]}}, br_offset, 2'b00};

    always_comb begin
        pc_next = pc_plus4;
        case (kind)
            RD_JUMP:   pc_next = {pc_plus4[ADDR_W-1:JTARGET_W+2], ju_target, 2'b00};
            RD_BRANCH: pc_next = pc + br_disp;
            default:   pc_next = pc_plus4;
        endcase
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// PC register and two-state instruction fetch FSM driven by ControlUnit stage strobes.
// Optional completed-fetch counter enabled by defining IFU_FETCH_COUNT_EN.
module instr_fetch_unit
    import cpu_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       DATA_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 top_en,
    input  logic                 if_en,
    input  logic                 ju_en,
    input  logic                 br_en,
    input  logic                 br_taken,
    input  logic [BOFF_W-1:0]    br_offset,
    input  logic [JTARGET_W-1:0] ju_target,
    output logic [ADDR_W-1:0]    imem_addr,
    output logic                 imem_rd,
    input  logic [DATA_W-1:0]    imem_rdata,
    output logic [ADDR_W-1:0]    pc,
    output logic [ADDR_W-1:0]    pc_plus4,
    output logic [DATA_W-1:0]    instr,
    output logic                 instr_valid,
    output logic                 fetch_busy,
    output logic                 fetch_err,
    output logic [31:0]          fetch_count
);

    ifu_state_t        state, state_n;
    redir_kind_t       kind;
    logic [ADDR_W-1:0] pc_next;
    logic [ADDR_W-1:0] pc_n, addr_n;
    logic [DATA_W-1:0] instr_n;
    logic              rd_n, valid_n, err_n;
    logic              fetch_pend, pend_n;
    logic              do_jump, do_branch, redirect, fetch_req;

    assign do_jump   = top_en & ju_en;
    assign do_branch = top_en & br_en & br_taken & ~ju_en;
    assign redirect  = do_jump | do_branch;
    assign fetch_req = top_en & (if_en | fetch_pend);
    assign kind      = do_jump ? RD_JUMP : (do_branch ? RD_BRANCH : RD_NONE);

    pc_next_calc #(
        .ADDR_W (ADDR_W)
    ) u_pc_next_calc (
        .pc        (pc),
        .kind      (kind),
        .br_offset (br_offset),
        .ju_target (ju_target),
        .pc_plus4  (pc_plus4),
        .pc_next   (pc_next)
    );

    assign fetch_busy = (state == WAIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            instr       <= '0;
            imem_addr   <= RESET_PC;
            imem_rd     <= 1'b0;
            instr_valid <= 1'b0;
            fetch_err   <= 1'b0;
            fetch_pend  <= 1'b0;
        end else begin
            state       <= state_n;
            pc          <= pc_n;
            instr       <= instr_n;
            imem_addr   <= addr_n;
            imem_rd     <= rd_n;
            instr_valid <= valid_n;
            fetch_err   <= err_n;
            fetch_pend  <= pend_n;
        end
    end

    always_comb begin
        state_n = state;
        pc_n    = pc;
        instr_n = instr;
        addr_n  = imem_addr;
        rd_n    = 1'b0;
        valid_n = 1'b0;
        err_n   = fetch_err;
        pend_n  = fetch_pend;
        case (state)
            IDLE: begin
                // A redirect pre-empts the fetch; the fetch is remembered and issued from the new PC.
                if (redirect) begin
                    pc_n   = pc_next;
                    pend_n = fetch_pend | (top_en & if_en);
                end else if (fetch_req) begin
                    addr_n  = pc;
                    rd_n    = 1'b1;
                    state_n = WAIT;
                    pend_n  = 1'b0;
                end
            end
            WAIT: begin
                // pc_next falls back to pc + 4 when no redirect arrives during the wait.
                instr_n = imem_rdata;
                valid_n = 1'b1;
                pc_n    = pc_next;
                state_n = IDLE;
                if (top_en & if_en) begin
                    err_n = 1'b1;
                end
            end
        endcase
    end

`ifdef IFU_FETCH_COUNT_EN
    logic [31:0] count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (state == WAIT) begin
            count_q <= count_q + 32'd1;
        end
    end

    assign fetch_count = count_q;
`else
    assign fetch_count = '0;
`endif

endmodule
